// File: rtl/frame_buffer_scheduler.sv
// frame_buffer_scheduler: triple-buffer rotation and capture sequencing for the SDRAM frame store; FB_SNAPSHOT_EN adds single-frame capture.
// Latency: all outputs registered, each response visible one cycle after the triggering pulse.
// Backpressure: none; every event pulse is consumed in the cycle it arrives.
module frame_buffer_scheduler #(
    parameter int                ADDR_W     = 23,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 23'h000000,
    parameter logic [ADDR_W-1:0] BUF_STRIDE = 23'h080000
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iSTART,
    input  logic              iSTOP,
    input  logic              iSNAP,
    input  logic              iWR_SOF,
    input  logic              iWR_EOF,
    input  logic              iRD_SOF,
    output logic [ADDR_W-1:0] oWR_BASE,
    output logic [ADDR_W-1:0] oRD_BASE,
    output logic              oWR_LOAD,
    output logic              oRD_LOAD,
    output logic              oWR_EN,
    output logic [1:0]        oSTATE,
    output logic [15:0]       oFRAME_CNT,
    output logic [15:0]       oDROP_CNT
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARM      = 2'd1,
        CAPTURE  = 2'd2,
        STOPPING = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [1:0]  wr_idx, rdy_idx, rd_idx;
    logic [1:0]  wr_idx_n, rdy_idx_n, rd_idx_n;
    logic        rdy_valid, rdy_valid_n;
    logic        in_frame, in_frame_n;
    logic        wr_load_n, rd_load_n, publish;
    logic [15:0] frame_cnt_n, drop_cnt_n;

`ifdef FB_SNAPSHOT_EN
    logic single, single_n;
`else
    logic unused_snap;
    assign unused_snap = iSNAP;
`endif

    function automatic logic [ADDR_W-1:0] base_of(input logic [1:0] idx);
        case (idx)
            2'd0:    base_of = BASE_ADDR;
            2'd1:    base_of = BASE_ADDR + BUF_STRIDE;
            default: base_of = BASE_ADDR + BUF_STRIDE + BUF_STRIDE;
        endcase
    endfunction

    always_comb begin
        state_n     = state;
        wr_idx_n    = wr_idx;
        rdy_idx_n   = rdy_idx;
        rd_idx_n    = rd_idx;
        rdy_valid_n = rdy_valid;
        in_frame_n  = in_frame;
        frame_cnt_n = oFRAME_CNT;
        drop_cnt_n  = oDROP_CNT;
        wr_load_n   = 1'b0;
        rd_load_n   = 1'b0;
        publish     = 1'b0;
`ifdef FB_SNAPSHOT_EN
        single_n    = single;
`endif
        case (state)
            IDLE: begin
                if (iSTART && !iSTOP) begin
                    state_n = ARM;
                end
`ifdef FB_SNAPSHOT_EN
                else if (iSNAP && !iSTOP) begin
                    state_n  = ARM;
                    single_n = 1'b1;
                end
`endif
            end
            ARM: begin
                if (iSTOP) begin
                    state_n = IDLE;
                end else if (iWR_SOF) begin
                    state_n    = CAPTURE;
                    in_frame_n = 1'b1;
                    wr_load_n  = 1'b1;
                end
            end
            CAPTURE: begin
                // EOF is resolved before SOF so a back-to-back frame boundary publishes first
                if (iWR_EOF && in_frame) begin
                    publish    = 1'b1;
                    in_frame_n = 1'b0;
                end
`ifdef FB_SNAPSHOT_EN
                if (publish && single) begin
                    state_n  = IDLE;
                    single_n = 1'b0;
                end else
`endif
                begin
                    if (iWR_SOF) begin
                        in_frame_n = 1'b1;
                        wr_load_n  = 1'b1;
                    end
                    if (iSTOP) begin
                        state_n = in_frame_n ? STOPPING : IDLE;
                    end
                end
            end
            STOPPING: begin
                if (iWR_EOF) begin
                    publish    = 1'b1;
                    in_frame_n = 1'b0;
                    state_n    = IDLE;
`ifdef FB_SNAPSHOT_EN
                    single_n   = 1'b0;
`endif
                end
                if (iSTART && !iSTOP) begin
                    state_n = CAPTURE;
                end
            end
            default: state_n = IDLE;
        endcase

`ifdef FB_SNAPSHOT_EN
        if (iSTART && !iSTOP) begin
            single_n = 1'b0;
        end
`endif

        if (publish) begin
            wr_idx_n    = rdy_idx;
            rdy_idx_n   = wr_idx;
            rdy_valid_n = 1'b1;
            frame_cnt_n = oFRAME_CNT + 16'd1;
            if (rdy_valid && (oDROP_CNT != 16'hFFFF)) begin
                drop_cnt_n = oDROP_CNT + 16'd1;
            end
        end

        // Read swap sees the post-publish ready buffer; with nothing new the display repeats its frame
        if (iRD_SOF) begin
            rd_load_n = 1'b1;
            if (rdy_valid_n) begin
                rd_idx_n    = rdy_idx_n;
                rdy_idx_n   = rd_idx;
                rdy_valid_n = 1'b0;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state      <= IDLE;
            wr_idx     <= 2'd0;
            rdy_idx    <= 2'd2;
            rd_idx     <= 2'd1;
            rdy_valid  <= 1'b0;
            in_frame   <= 1'b0;
            oWR_LOAD   <= 1'b0;
            oRD_LOAD   <= 1'b0;
            oFRAME_CNT <= 16'd0;
            oDROP_CNT  <= 16'd0;
            oWR_BASE   <= BASE_ADDR;
            oRD_BASE   <= BASE_ADDR + BUF_STRIDE;
`ifdef FB_SNAPSHOT_EN
            single     <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            wr_idx     <= wr_idx_n;
            rdy_idx    <= rdy_idx_n;
            rd_idx     <= rd_idx_n;
            rdy_valid  <= rdy_valid_n;
            in_frame   <= in_frame_n;
            oWR_LOAD   <= wr_load_n;
            oRD_LOAD   <= rd_load_n;
            oFRAME_CNT <= frame_cnt_n;
            oDROP_CNT  <= drop_cnt_n;
            oWR_BASE   <= base_of(wr_idx_n);
            oRD_BASE   <= base_of(rd_idx_n);
`ifdef FB_SNAPSHOT_EN
            single     <= single_n;
`endif
        end
    end

    assign oSTATE = state;
    assign oWR_EN = in_frame;

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Bench for frame_buffer_scheduler: buffer-role model checked every cycle plus directed literal expectations.
module tb_frame_buffer_scheduler;

    localparam int            AW     = 23;
    localparam logic [AW-1:0] BASE   = 23'h000000;
    localparam logic [AW-1:0] STRIDE = 23'h080000;

    localparam int EV_START = 1;
    localparam int EV_STOP  = 2;
    localparam int EV_SNAP  = 4;
    localparam int EV_WSOF  = 8;
    localparam int EV_WEOF  = 16;
    localparam int EV_RSOF  = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic          start = 1'b0, stop = 1'b0, snap = 1'b0;
    logic          wsof = 1'b0, weof = 1'b0, rsof = 1'b0;
    logic [AW-1:0] wr_base, rd_base;
    logic          wr_load, rd_load, wr_en;
    logic [1:0]    st;
    logic [15:0]   fcnt, dcnt;

    frame_buffer_scheduler #(
        .ADDR_W     (AW),
        .BASE_ADDR  (BASE),
        .BUF_STRIDE (STRIDE)
    ) dut (
        .iCLK       (clk),
        .iRST_N     (rst_n),
        .iSTART     (start),
        .iSTOP      (stop),
        .iSNAP      (snap),
        .iWR_SOF    (wsof),
        .iWR_EOF    (weof),
        .iRD_SOF    (rsof),
        .oWR_BASE   (wr_base),
        .oRD_BASE   (rd_base),
        .oWR_LOAD   (wr_load),
        .oRD_LOAD   (rd_load),
        .oWR_EN     (wr_en),
        .oSTATE     (st),
        .oFRAME_CNT (fcnt),
        .oDROP_CNT  (dcnt)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Model: each physical buffer carries a role (0 write, 1 ready, 2 read)
    int role [3] = '{0, 2, 1};
    int m_state = 0;
    int m_fc = 0, m_dc = 0;
    bit m_inf = 0, m_rv = 0, m_wl = 0, m_rl = 0, m_single = 0;
    bit cmp_en = 0;

    function automatic int holder(input int r);
        for (int b = 0; b < 3; b++) if (role[b] == r) return b;
        return -1;
    endfunction

    function automatic longint addr_of(input int b);
        return longint'(BASE) + longint'(b) * longint'(STRIDE);
    endfunction

    task automatic exchange(input int ra, input int rb);
        int ba, bb;
        ba = holder(ra);
        bb = holder(rb);
        role[ba] = rb;
        role[bb] = ra;
    endtask

    task automatic model_step();
        bit pub;
        bit snap_done;
        pub = 0;
        snap_done = 0;
        m_wl = 0;
        m_rl = 0;
        if (!rst_n) begin
            role = '{0, 2, 1};
            m_state = 0; m_fc = 0; m_dc = 0;
            m_inf = 0; m_rv = 0; m_single = 0;
            return;
        end
        case (m_state)
            0: begin
                if (start && !stop) m_state = 1;
`ifdef FB_SNAPSHOT_EN
                else if (snap && !stop) begin m_state = 1; m_single = 1; end
`endif
            end
            1: begin
                if (stop) m_state = 0;
                else if (wsof) begin m_state = 2; m_inf = 1; m_wl = 1; end
            end
            2: begin
                if (weof && m_inf) begin pub = 1; m_inf = 0; end
`ifdef FB_SNAPSHOT_EN
                if (pub && m_single) begin m_state = 0; m_single = 0; snap_done = 1; end
`endif
                if (!snap_done) begin
                    if (wsof) begin m_inf = 1; m_wl = 1; end
                    if (stop) m_state = m_inf ? 3 : 0;
                end
            end
            default: begin
                if (weof) begin pub = 1; m_inf = 0; m_state = 0; m_single = 0; end
                if (start && !stop) m_state = 2;
            end
        endcase
        if (start && !stop) m_single = 0;
        if (pub) begin
            exchange(0, 1);
            if (m_rv && m_dc < 65535) m_dc++;
            m_rv = 1;
            m_fc = (m_fc + 1) % 65536;
        end
        if (rsof) begin
            m_rl = 1;
            if (m_rv) begin exchange(2, 1); m_rv = 0; end
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (cmp_en) begin
            check("m_state",   longint'(st),      longint'(m_state));
            check("m_wr_base", longint'(wr_base), addr_of(holder(0)));
            check("m_rd_base", longint'(rd_base), addr_of(holder(2)));
            check("m_wr_load", longint'(wr_load), longint'(m_wl));
            check("m_rd_load", longint'(rd_load), longint'(m_rl));
            check("m_wr_en",   longint'(wr_en),   longint'(m_inf));
            check("m_fcnt",    longint'(fcnt),    longint'(m_fc));
            check("m_dcnt",    longint'(dcnt),    longint'(m_dc));
        end
    end

    task automatic cyc(input int m);
        start = m[0];
        stop  = m[1];
        snap  = m[2];
        wsof  = m[3];
        weof  = m[4];
        rsof  = m[5];
        @(posedge clk);
        #1;
        start = 0; stop = 0; snap = 0; wsof = 0; weof = 0; rsof = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"},   longint'(st),      0);
        check({tag, "_wr_base"}, longint'(wr_base), 'h000000);
        check({tag, "_rd_base"}, longint'(rd_base), 'h080000);
        check({tag, "_fcnt"},    longint'(fcnt),    0);
        check({tag, "_dcnt"},    longint'(dcnt),    0);
        check({tag, "_wr_en"},   longint'(wr_en),   0);
        check({tag, "_wr_load"}, longint'(wr_load), 0);
        check({tag, "_rd_load"}, longint'(rd_load), 0);
    endtask

    initial begin
        cyc(0);
        cyc(0);
        rst_n = 1;
        cmp_en = 1;
        check_reset_values("rst");

        // idle ignores camera events and simultaneous start/stop
        cyc(EV_WSOF | EV_WEOF);
        check("idle_cam_state", longint'(st), 0);
        check("idle_cam_load",  longint'(wr_load), 0);
`ifndef FB_SNAPSHOT_EN
        cyc(EV_SNAP);
        check("snap_ignored", longint'(st), 0);
`endif
        cyc(EV_START | EV_STOP);
        check("start_stop_stop_wins", longint'(st), 0);
        cyc(EV_START);
        check("arm_state", longint'(st), 1);
        cyc(EV_WEOF);
        check("arm_eof_ignored", longint'(fcnt), 0);
        cyc(EV_STOP);
        check("arm_stop", longint'(st), 0);

        // first captured frame
        cyc(EV_START);
        cyc(EV_WSOF);
        check("t1_state",   longint'(st), 2);
        check("t1_wr_load", longint'(wr_load), 1);
        check("t1_wr_base", longint'(wr_base), 'h000000);
        check("t1_wr_en",   longint'(wr_en), 1);
        cyc(0);
        check("t1_load_one_cycle", longint'(wr_load), 0);
        cyc(EV_WEOF);
        check("t1_fcnt",    longint'(fcnt), 1);
        check("t1_wr_base2", longint'(wr_base), 'h100000);
        check("t1_wr_en_off", longint'(wr_en), 0);

        // display pickup and repeat
        cyc(EV_RSOF);
        check("t2_rd_load", longint'(rd_load), 1);
        check("t2_rd_base", longint'(rd_base), 'h000000);
        cyc(0);
        check("t2_rd_load_off", longint'(rd_load), 0);
        cyc(EV_RSOF);
        check("t2_rd_load2", longint'(rd_load), 1);
        check("t2_rd_repeat", longint'(rd_base), 'h000000);

        // three publishes without display
        for (int i = 0; i < 3; i++) begin
            cyc(EV_WSOF);
            cyc(EV_WEOF);
        end
        check("t3_drop",    longint'(dcnt), 2);
        check("t3_fcnt",    longint'(fcnt), 4);
        check("t3_wr_base", longint'(wr_base), 'h080000);
        check("t3_rd_base", longint'(rd_base), 'h000000);

        // publish coincident with display start
        cyc(EV_RSOF);
        check("t4_rd_pre", longint'(rd_base), 'h100000);
        cyc(EV_WSOF);
        cyc(EV_WEOF | EV_RSOF);
        check("t4_rd_base", longint'(rd_base), 'h080000);
        check("t4_wr_base", longint'(wr_base), 'h000000);
        check("t4_drop",    longint'(dcnt), 2);
        check("t4_fcnt",    longint'(fcnt), 5);
        cyc(EV_RSOF);
        check("t4_rdy_cleared", longint'(rd_base), 'h080000);

        // missing EOF restarts the same buffer
        cyc(EV_WSOF);
        cyc(EV_WSOF);
        check("miss_eof_load", longint'(wr_load), 1);
        check("miss_eof_fcnt", longint'(fcnt), 5);
        check("miss_eof_base", longint'(wr_base), 'h000000);
        cyc(EV_WSOF | EV_WEOF);
        check("sof_eof_fcnt", longint'(fcnt), 6);
        check("sof_eof_load", longint'(wr_load), 1);
        check("sof_eof_wr_en", longint'(wr_en), 1);
        check("sof_eof_base", longint'(wr_base), 'h100000);

        // stop mid-frame
        cyc(EV_STOP);
        check("t5_state", longint'(st), 3);
        check("t5_wr_en", longint'(wr_en), 1);
        cyc(EV_WSOF);
        check("t5_sof_ignored", longint'(wr_load), 0);
        check("t5_wr_en_hold", longint'(wr_en), 1);
        cyc(EV_WEOF);
        check("t5_idle", longint'(st), 0);
        check("t5_fcnt", longint'(fcnt), 7);
        check("t5_drop", longint'(dcnt), 3);
        check("t5_wr_base", longint'(wr_base), 'h000000);

        // cancelled stop, then reset mid-frame
        cyc(EV_START);
        cyc(EV_WSOF);
        cyc(EV_STOP);
        check("cancel_pre", longint'(st), 3);
        cyc(EV_START);
        check("cancel_state", longint'(st), 2);
        check("cancel_wr_en", longint'(wr_en), 1);
        rst_n = 0;
        cyc(0);
        rst_n = 1;
        check_reset_values("midrst");

`ifdef FB_SNAPSHOT_EN
        cyc(EV_SNAP);
        check("snap_arm", longint'(st), 1);
        cyc(EV_WSOF);
        cyc(EV_WEOF);
        check("snap_fcnt", longint'(fcnt), 1);
        check("snap_idle", longint'(st), 0);
        cyc(EV_WSOF);
        check("snap_no_load", longint'(wr_load), 0);
        cyc(EV_RSOF);
        check("snap_rd_base", longint'(rd_base), 'h000000);
`endif

        cyc(0);
        cyc(0);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
